// File: rtl/hack_pkg.sv
// Shared Hack-platform constants: data word width and the RAM8 address width.
package hack_pkg;

  localparam int WORD_W      = 16;
  localparam int RAM8_ADDR_W = 3;

  typedef logic [WORD_W-1:0] word_t;

endpackage : hack_pkg

// File: rtl/register16.sv
// WIDTH-bit storage register with load enable and asynchronous active-high clear.
module register16 #(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out
);

  logic [WIDTH-1:0] data_reg;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      data_reg <= '0;
    end else if (load) begin
      data_reg <= in;
    end
  end

  assign out = data_reg;

endmodule : register16

// File: rtl/ram8.sv
// Hack RAM8: eight 16-bit registers, combinational read through an addr mux,
// synchronous write steered to one register by a load demultiplexer.
module ram8
  import hack_pkg::*;
#(
  parameter int WIDTH  = WORD_W,
  parameter int ADDR_W = RAM8_ADDR_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [WIDTH-1:0]  in,
  input  logic              load,
  input  logic [ADDR_W-1:0] addr,
  output logic [WIDTH-1:0]  out
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [WIDTH-1:0] word_q [DEPTH];

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_word
      logic load_sel;

      // An X address compares to X here, which never enables a register.
      assign load_sel = load && (addr == ADDR_W'(gi));

      register16 #(
        .WIDTH(WIDTH)
      ) u_reg (
        .clock(clock),
        .reset(reset),
        .load (load_sel),
        .in   (in),
        .out  (word_q[gi])
      );
    end
  endgenerate

  assign out = word_q[addr];

endmodule : ram8

// File: tb/tb_ram8.sv
// Self-checking bench for ram8: directed Hack tests plus random traffic
// checked against a plain array model of the eight words.
module tb_ram8;

  logic        clock;
  logic        reset;
  logic [15:0] in;
  logic        load;
  logic [2:0]  addr;
  logic [15:0] out;

  int total = 0;
  int bad   = 0;

  logic [15:0] model [8];

  ram8 dut (
    .clock(clock),
    .reset(reset),
    .in   (in),
    .load (load),
    .addr (addr),
    .out  (out)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic clear_model();
    for (int i = 0; i < 8; i++) model[i] = 16'h0000;
  endtask

  // Present a transaction at the falling edge, let the rising edge take it,
  // then check the read value just after the edge.
  task automatic do_cycle(input logic [2:0] a, input logic [15:0] d, input logic ld,
                          input string tag);
    logic [15:0] exp_before;
    @(negedge clock);
    addr = a; in = d; load = ld;
    #1;
    exp_before = model[a];
    total++;
    if (out !== exp_before) begin
      bad++;
      $display("FAIL %s pre-edge addr=%0d got=%h want=%h", tag, a, out, exp_before);
    end
    @(posedge clock);
    #1;
    if (ld) model[a] = d;
    total++;
    if (out !== model[a]) begin
      bad++;
      $display("FAIL %s post-edge addr=%0d got=%h want=%h", tag, a, out, model[a]);
    end
    $display("txn %s addr=%0d in=%h load=%0b out=%h", tag, a, d, ld, out);
    load = 1'b0;
  endtask

  // Sweep every address between edges and compare against the model.
  task automatic sweep(input string tag);
    @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      addr = 3'(i);
      #1;
      total++;
      if (out !== model[i]) begin
        bad++;
        $display("FAIL %s addr=%0d got=%h want=%h", tag, i, out, model[i]);
      end
      $display("txn %s read addr=%0d out=%h", tag, i, out);
    end
  endtask

  task automatic test_reset();
    @(negedge clock);
    load = 1'b0; in = 16'h0000; addr = 3'd0;
    #1 reset = 1'b1;
    #2 reset = 1'b0;
    clear_model();
    sweep("reset_sweep");
  endtask

  task automatic test_spec_writes();
    do_cycle(3'b011, 16'b1100100011010101, 1'b1, "write_a3");
    do_cycle(3'b100, 16'b1111100001111010, 1'b1, "write_a4");
    @(negedge clock);
    addr = 3'b011;
    #1;
    total++;
    if (out !== 16'b1100100011010101) begin
      bad++;
      $display("FAIL readback_a3 got=%h want=%h", out, 16'b1100100011010101);
    end
    $display("txn readback_a3 out=%h", out);
  endtask

  task automatic test_load_low();
    do_cycle(3'b011, 16'b1010101011100011, 1'b0, "load_low");
    total++;
    if (out !== 16'b1100100011010101) begin
      bad++;
      $display("FAIL load_low_hold got=%h want=%h", out, 16'b1100100011010101);
    end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 8; i++) do_cycle(3'(i), 16'(i), 1'b1, "fill");
    sweep("fill_sweep");
    // Address hops without any clock edge: out must follow at once.
    @(negedge clock);
    for (int k = 0; k < 8; k++) begin
      logic [2:0] a;
      a = 3'($urandom_range(0, 7));
      addr = a;
      #1;
      total++;
      if (out !== 16'(a)) begin
        bad++;
        $display("FAIL comb_read addr=%0d got=%h want=%h", a, out, 16'(a));
      end
      $display("txn comb_read addr=%0d out=%h", a, out);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 120; n++) begin
      do_cycle(3'($urandom_range(0, 7)), 16'($urandom),
               ($urandom_range(0, 3) != 0), "random");
    end
    sweep("random_sweep");
  endtask

  task automatic test_reset_during_write();
    for (int i = 0; i < 8; i++) do_cycle(3'(i), 16'($urandom) | 16'h0001, 1'b1, "preload");
    @(posedge clock);
    #2;
    addr = 3'd5; load = 1'b1; in = 16'hFFFF; reset = 1'b1;
    #1;
    clear_model();
    total++;
    if (out !== 16'h0000) begin
      bad++;
      $display("FAIL async_reset got=%h want=0000", out);
    end
    $display("txn async_reset out=%h", out);
    // Hold reset across a rising edge with the write still requested.
    @(posedge clock);
    #1;
    total++;
    if (out !== 16'h0000) begin
      bad++;
      $display("FAIL reset_dominates got=%h want=0000", out);
    end
    @(negedge clock);
    load = 1'b0;
    reset = 1'b0;
    sweep("post_reset_sweep");
  endtask

  initial begin
    reset = 1'b0;
    load  = 1'b0;
    in    = 16'h0000;
    addr  = 3'd0;
    clear_model();
    test_reset();
    test_spec_writes();
    test_load_low();
    test_fill();
    test_random();
    test_reset_during_write();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "simulation time limit");
  end

endmodule : tb_ram8
